enocoro_linear_serial: RTL
==========================

Name: enocoro_linear_serial

Overview:
- Digit-serial implementation of the Enocoro-128v2 linear function L over GF(2^8), generalised to a configurable digit width.
- Accepts one byte pair (u0, u1) as a digit stream and returns (v0, v1) as a digit stream. Both streams use valid/ready handshakes.
- Sits between the state buffer and the rho round datapath.
- Adds a per-pair pass-through mode and a synchronous flush.

Parameters:
- DIGIT_W, 4, digit width in bits; legal values are 1, 2, 4, 8. ND = 8/DIGIT_W digits per byte.
- POLY, 8'h1D, low byte of the field reduction polynomial (x^8+x^4+x^3+x^2+1).

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous abort of the current pair.
- in_valid  input  1  in_data/in_mode valid.
- in_ready  output  1  block can accept a digit.
- in_data  input  DIGIT_W  input digit.
- in_mode  input  1  0 = apply L, 1 = pass-through; sampled only with the first digit of u0.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts the digit.
- out_data  output  DIGIT_W  output digit.

Behaviour:
- Function, mode 0: v0 = u0 ^ u1 and v1 = u0 ^ (0x02 * u1), where 0x02 * x = (x<<1)[7:0] ^ (x[7] ? POLY : 0).
- Function, mode 1: v0 = u0 and v1 = u1.
- Digit order: input is ND digits of u0 then ND digits of u1, least-significant digit first. Output is ND digits of v0 then ND digits of v1, LSD first.
- FSM state LOAD:
  - in_ready = 1 (when flush = 0), out_valid = 0.
  - Each in_valid & in_ready edge stores the digit into a 16-bit buffer at index in_cnt and increments in_cnt (0 .. 2ND-1).
  - Acceptance of digit 2ND-1 moves to EMIT. The whole u1 is needed before any v1 digit, because the reduction depends on u1[7].
- FSM state EMIT:
  - in_ready = 0, out_valid = 1.
  - out_data = digit out_cnt of {v1, v0}, computed from the buffer.
  - Each out_valid & out_ready edge increments out_cnt (0 .. 2ND-1).
  - Acceptance of digit 2ND-1 returns to LOAD and clears both counters. in_ready = 1 in the next cycle.
- Latency: out_valid rises in the cycle immediately after the final input digit is accepted.
- Minimum period is 4*ND cycles per pair, with no overlap of load and emit.
- Backpressure: while out_ready = 0 in EMIT, out_data, out_cnt and buffer are held stable. in_valid is ignored in EMIT.
- out_data is driven 0 whenever out_valid = 0.
- flush:
  - Effect on the next edge: state goes to LOAD, counters and mode clear, and the buffer is unchanged (don't care).
  - During the flush cycle, in_ready = 0 and out_valid is forced to 0. No handshake completes, so a simultaneously presented digit is discarded.
- Reset:
  - Asynchronous reset at any time, including mid-LOAD or mid-EMIT, gives state LOAD, counters 0, mode 0, buffer 0.
  - Outputs during and after reset: in_ready = 1, out_valid = 0, out_data = 0.
- Counters wrap only through the state transitions above; they never exceed 2ND-1.
- Legality: DIGIT_W outside {1, 2, 4, 8} is a configuration error. Elaboration halts via a generate-time check.

Test Plan:
- DIGIT_W=4, mode 0, u0=0x5A, u1=0x81. Input digits A,5,1,8. Outputs are B,D,5,4 (v0=0xDB, v1=0x45). out_valid rises 1 cycle after the 4th input digit is accepted.
- DIGIT_W=8, mode 0, u0=0x00, u1=0xFF. Output is FF then E3, exercising the reduction path. DIGIT_W=1 with u0=0x00, u1=0x01 gives out bits LSB-first for 0x01 then 0x02.
- DIGIT_W=4, in_mode=1 on the first digit, with u0=0x5A, u1=0x81. Output is A,5,1,8. in_mode toggled on later digits has no effect, and the next pair reverts to the mode sampled on its own first digit.
- Backpressure: drop out_ready for 3 cycles after the 2nd output digit. out_data holds at D, in_ready stays 0 with in_valid = 1, and the sequence completes B,D,5,4. Random out_ready/in_valid over 1000 pairs matches the reference model.
- Flush after 3 input digits, with flush coincident with an in_valid digit. That digit is discarded. The next full pair 0x5A/0x81 yields B,D,5,4.
- reset_n pulsed low mid-EMIT (async, not clock-aligned). out_valid = 0 and in_ready = 1 immediately. The next pair processes correctly.

Source files
------------

// File: rtl/enocoro_linear_serial.sv
// Digit-serial Enocoro-128v2 linear function L over GF(2^8).
// Loads u0 then u1 as LSD-first digit streams, then emits v0 then v1.
module enocoro_linear_serial #(
  parameter int unsigned DIGIT_W = 4,
  parameter logic [7:0]  POLY    = 8'h1D
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIGIT_W-1:0] in_data,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIGIT_W-1:0] out_data
);

  localparam int unsigned ND    = 8 / DIGIT_W;
  localparam int unsigned NDIG  = 2 * ND;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  // Reject digit widths that do not divide a byte evenly into a power-of-two count.
  if (!(DIGIT_W == 1 || DIGIT_W == 2 || DIGIT_W == 4 || DIGIT_W == 8)) begin : g_bad_digit_w
    $fatal(1, "enocoro_linear_serial: DIGIT_W must be 1, 2, 4 or 8");
  end

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   in_cnt;
  logic [CNT_W-1:0]   out_cnt;
  logic               mode;
  logic [DIGIT_W-1:0] dig_buf [NDIG];

  logic [15:0]        u_word;
  logic [15:0]        v_word;
  logic [7:0]         u0;
  logic [7:0]         u1;
  logic [7:0]         u1_x2;
  logic [7:0]         v0;
  logic [7:0]         v1;
  logic [DIGIT_W-1:0] v_dig [NDIG];

  // Evaluate L on the buffered pair and split {v1, v0} back into digits.
  always_comb begin
    u_word = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      u_word[i*DIGIT_W +: DIGIT_W] = dig_buf[i];
    end
    u0    = u_word[7:0];
    u1    = u_word[15:8];
    // Multiplication by x: shift, reducing by POLY when the top bit falls out.
    u1_x2 = {u1[6:0], 1'b0} ^ (u1[7] ? POLY : 8'h00);
    v0    = mode ? u0 : (u0 ^ u1);
    v1    = mode ? u1 : (u0 ^ u1_x2);
    v_word = {v1, v0};
    for (int unsigned i = 0; i < NDIG; i++) begin
      v_dig[i] = v_word[i*DIGIT_W +: DIGIT_W];
    end
  end

  // Handshake qualifiers; flush blocks both sides for its cycle.
  assign in_ready  = (state == LOAD) && !flush;
  assign out_valid = (state == EMIT) && !flush;
  assign out_data  = out_valid ? v_dig[out_cnt] : '0;

  // Load/emit sequencing, digit buffer and pass-through mode capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= LOAD;
      in_cnt  <= '0;
      out_cnt <= '0;
      mode    <= 1'b0;
      for (int unsigned i = 0; i < NDIG; i++) begin
        dig_buf[i] <= '0;
      end
    end else if (flush) begin
      state   <= LOAD;
      in_cnt  <= '0;
      out_cnt <= '0;
      mode    <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          if (in_valid && in_ready) begin
            dig_buf[in_cnt] <= in_data;
            if (in_cnt == '0) begin
              mode <= in_mode;
            end
            // v1 needs u1[7], so emission waits for the whole pair.
            if (in_cnt == LAST) begin
              state <= EMIT;
            end else begin
              in_cnt <= in_cnt + CNT_W'(1);
            end
          end
        end
        EMIT: begin
          if (out_valid && out_ready) begin
            if (out_cnt == LAST) begin
              state   <= LOAD;
              in_cnt  <= '0;
              out_cnt <= '0;
            end else begin
              out_cnt <= out_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
